// File: rtl/switch_port.sv
// Memory-mapped switch input port: 2-flop sync, shared-counter debounce, change/overrun status.
// Define SWITCH_PORT_IRQ_EN to drive the registered change-pending interrupt; otherwise irq is tied low.
module switch_port #(
  parameter int SW_W            = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cs,
  input  logic            rd,
  input  logic            addr_sel,
  input  logic [SW_W-1:0] sw,
  output logic [31:0]     rdata,
  output logic            irq
);

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_COUNT = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             state;
  logic [CNT_W-1:0] cnt;
  logic [SW_W-1:0]  s1, s2, stable, chg, chg_next;
  logic             ovr, ovr_next;
  logic             pending, accept, status_rd, differs;

  assign differs   = (s2 != stable);
  assign pending   = |chg;
  assign status_rd = cs & rd & addr_sel;
  assign accept    = (state == STATE_COUNT) && differs && (cnt == CNT_MAX);

  // An accept on the status-read edge restarts the change mask instead of merging into it.
  always_comb begin
    chg_next = chg;
    ovr_next = ovr;
    if (status_rd) begin
      chg_next = '0;
      ovr_next = 1'b0;
    end
    if (accept) begin
      if (status_rd) begin
        chg_next = stable ^ s2;
      end else begin
        chg_next = chg | (stable ^ s2);
        ovr_next = ovr | pending;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      chg    <= '0;
      ovr    <= 1'b0;
      cnt    <= '0;
      state  <= STATE_IDLE;
    end else begin
      s1  <= sw;
      s2  <= s1;
      chg <= chg_next;
      ovr <= ovr_next;
      case (state)
        STATE_IDLE: begin
          if (differs) begin
            state <= STATE_COUNT;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        default: begin
          if (!differs) begin
            state <= STATE_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            stable <= s2;
            state  <= STATE_IDLE;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (cs && rd) begin
      if (addr_sel) rdata = {16'(chg), 14'b0, ovr, pending};
      else          rdata = 32'(stable);
    end
  end

`ifdef SWITCH_PORT_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= |chg_next;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_switch_port.sv
// Directed test for switch_port with DEBOUNCE_CYCLES=4: sync latency, glitch reject, overrun, read/accept collision, mid-count reset.
module tb_switch_port;

`ifdef SWITCH_PORT_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        rd = 1'b0;
  logic        addr_sel = 1'b0;
  logic [15:0] sw = '0;
  logic [31:0] rdata;
  logic        irq;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  switch_port #(
    .SW_W(16),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cs(cs),
    .rd(rd),
    .addr_sel(addr_sel),
    .sw(sw),
    .rdata(rdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Read without letting a clock edge pass, so no side effect.
  task automatic look(input logic sel, input string tag, input logic [31:0] exp);
    cs = 1'b1; rd = 1'b1; addr_sel = sel;
    #1;
    check(tag, rdata, exp);
    cs = 1'b0; rd = 1'b0;
  endtask

  // STATUS read held across one edge, so the clear takes effect.
  task automatic status_read(input string tag, input logic [31:0] exp);
    cs = 1'b1; rd = 1'b1; addr_sel = 1'b1;
    #1;
    check(tag, rdata, exp);
    tick(1);
    cs = 1'b0; rd = 1'b0;
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    check("irq_rst", {31'b0, irq}, 32'h0);
    look(1'b0, "data_rst", 32'h0);
    look(1'b1, "status_rst", 32'h0);
    cs = 1'b0; rd = 1'b1; addr_sel = 1'b0;
    #1;
    check("rdata_no_cs", rdata, 32'h0);
    rd = 1'b0;

    // Step to 0x00A5: accepted on the 6th edge after the step.
    sw = 16'h00A5;
    tick(5);
    look(1'b0, "data_before_accept", 32'h0);
    check("irq_before_accept", {31'b0, irq}, 32'h0);
    tick(1);
    look(1'b0, "data_a5", 32'h0000_00A5);
    look(1'b1, "status_a5", 32'h00A5_0001);
    check("irq_a5", {31'b0, irq}, {31'b0, IRQ_ON});
    status_read("status_a5_rd", 32'h00A5_0001);
    check("irq_after_rd", {31'b0, irq}, 32'h0);
    look(1'b1, "status_cleared", 32'h0);

    // Bit 3 high for 3 synchronized cycles: bounces back before acceptance.
    sw = 16'h00AD;
    tick(3);
    sw = 16'h00A5;
    tick(8);
    look(1'b0, "data_glitch", 32'h0000_00A5);
    look(1'b1, "status_glitch", 32'h0);
    check("irq_glitch", {31'b0, irq}, 32'h0);

    // Two accepts with no status read in between: overrun.
    sw = 16'h00A4;
    tick(6);
    look(1'b1, "status_first", 32'h0001_0001);
    sw = 16'h0024;
    tick(6);
    look(1'b0, "data_ovr", 32'h0000_0024);
    look(1'b1, "status_ovr", 32'h0081_0003);
    check("irq_ovr", {31'b0, irq}, {31'b0, IRQ_ON});
    status_read("status_ovr_rd", 32'h0081_0003);
    look(1'b1, "status_ovr_cleared", 32'h0);

    // Status read landing on the same edge as an accept of bit 0.
    sw = 16'h0004;
    tick(6);
    look(1'b1, "status_bit5", 32'h0020_0001);
    sw = 16'h0005;
    tick(5);
    status_read("status_collide", 32'h0020_0001);
    look(1'b1, "status_after_collide", 32'h0001_0001);
    look(1'b0, "data_after_collide", 32'h0000_0005);
    check("irq_after_collide", {31'b0, irq}, {31'b0, IRQ_ON});
    status_read("status_collide_clr", 32'h0001_0001);

    // Back to 0, then reset at cnt=2 while moving to 0xFFFF.
    sw = 16'h0000;
    tick(6);
    status_read("status_zero", 32'h0005_0001);
    sw = 16'hFFFF;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    look(1'b0, "data_mid_rst", 32'h0);
    look(1'b1, "status_mid_rst", 32'h0);
    check("irq_mid_rst", {31'b0, irq}, 32'h0);
    tick(5);
    look(1'b0, "data_requal_wait", 32'h0);
    tick(1);
    look(1'b0, "data_requal", 32'h0000_FFFF);
    look(1'b1, "status_requal", 32'hFFFF_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
